// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM sequencer.
package sram_mem_controller_pkg;

  localparam int SRAM_DATA_W    = 16;
  localparam int DATA_BASE_DFLT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side request/response and SRAM pin bundle for the MEM-stage sequencer.
interface sram_mem_controller_if #(
    parameter int SRAM_ADDR_W = 18
);
    import sram_mem_controller_pkg::*;

    logic                   mem_read;
    logic                   mem_write;
    logic [31:0]            address;
    logic [31:0]            wdata;
    logic [31:0]            rdata;
    logic                   ready;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_dq_out;
    logic [SRAM_DATA_W-1:0] sram_dq_in;
    logic                   sram_dq_oe;
    logic                   sram_we_n;

    modport slave (
        input  mem_read, mem_write, address, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output mem_read, mem_write, address, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller_wait_counter.sv
// Phase wait counter: synchronous clear, counts while enabled, flags the last
// phase cycle (count == WAIT_CYCLES-1) and saturates there.
module sram_wait_counter
    import sram_mem_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != LAST))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == LAST);
endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage sequencer: splits a 32-bit LDR/STR into two timed 16-bit SRAM
// half-accesses and holds ready low (pipeline freeze) until the access is done.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int DATA_BASE   = DATA_BASE_DFLT,
    parameter int WAIT_CYCLES = 5,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_mem_controller_if.slave bus
);
    state_t                 r_state, w_next;
    logic                   r_is_write;
    logic [SRAM_ADDR_W-2:0] r_word;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;

    logic                   w_req, w_tc, w_clr, w_in_phase, w_unused;
    logic [31:0]            w_diff;
    logic [SRAM_ADDR_W-1:0] w_sram_addr;
    logic [SRAM_DATA_W-1:0] w_dq_out;
    logic                   w_oe, w_we_n;

    assign w_req  = bus.mem_read | bus.mem_write;
    assign w_diff = bus.address - 32'(DATA_BASE);
    // Byte offset bits and the part of the word index beyond the SRAM are dropped.
    assign w_unused = ^{w_diff[31:SRAM_ADDR_W+1], w_diff[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = ST_LOW;
            ST_LOW:  if (w_tc)  w_next = ST_HIGH;
            ST_HIGH: if (w_tc)  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_in_phase = (r_state == ST_LOW) || (r_state == ST_HIGH);
    // Held clear outside the phases so every phase starts counting from zero.
    assign w_clr = !w_in_phase || (w_next != r_state);

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_en  (w_in_phase),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_write <= 1'b0;
            r_word     <= '0;
            r_wdata    <= '0;
        end else if (r_state == ST_IDLE && w_req) begin
            r_is_write <= bus.mem_write;
            r_word     <= w_diff[SRAM_ADDR_W:2];
            r_wdata    <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (!r_is_write && w_tc) begin
            if (r_state == ST_LOW)  r_rdata[15:0]  <= bus.sram_dq_in;
            if (r_state == ST_HIGH) r_rdata[31:16] <= bus.sram_dq_in;
        end
    end

    // Bus is decoded from registered state only; we_n rises on the last
    // phase cycle so the SRAM latches while address and data stay stable.
    always_comb begin
        w_sram_addr = '0;
        w_dq_out    = '0;
        w_oe        = 1'b0;
        w_we_n      = 1'b1;
        if (w_in_phase) begin
            w_sram_addr = {r_word, (r_state == ST_HIGH)};
            if (r_is_write) begin
                w_oe     = 1'b1;
                w_dq_out = (r_state == ST_HIGH) ? r_wdata[31:16] : r_wdata[15:0];
                w_we_n   = w_tc;
            end
        end
    end

    assign bus.sram_addr   = w_sram_addr;
    assign bus.sram_dq_out = w_dq_out;
    assign bus.sram_dq_oe  = w_oe;
    assign bus.sram_we_n   = w_we_n;
    assign bus.rdata       = r_rdata;
    assign bus.ready       = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);
endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: cycle-level access model plus SRAM array model,
// with directed LDR/STR vectors and literal pins on the key cycles.
module tb_sram_mem_controller;
    localparam int W  = 5;
    localparam int AW = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sram_mem_controller_if #(.SRAM_ADDR_W(AW)) bus ();

    sram_mem_controller #(.DATA_BASE(1024), .WAIT_CYCLES(W), .SRAM_ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External SRAM: 16-bit words, written on the rising edge of we_n.
    logic [15:0] sram [0:31] = '{2: 16'h5678, 3: 16'h1234, default: 16'h0000};
    assign bus.sram_dq_in = sram[bus.sram_addr[4:0]];
    always @(posedge bus.sram_we_n)
        if (bus.sram_dq_oe) sram[bus.sram_addr[4:0]] <= bus.sram_dq_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: t = cycle index inside an access (0 idle, 1..2W phases, 2W+1 done).
    int          m_t = 0;
    logic        m_write = 1'b0;
    logic [31:0] m_word = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_mem [0:31] = '{1: 32'h12345678, default: 32'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t     <= 0;
            m_rdata <= '0;
        end else if (m_t == 0) begin
            if (bus.mem_read || bus.mem_write) begin
                m_t     <= 1;
                m_write <= bus.mem_write;
                m_word  <= (bus.address - 32'd1024) >> 2;
                m_wdata <= bus.wdata;
            end
        end else if (m_t == 2*W + 1) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == 2*W) begin
                if (m_write) m_mem[m_word[4:0]] <= m_wdata;
                else         m_rdata <= m_mem[m_word[4:0]];
            end
        end
    end

    always @(negedge clk) begin
        logic in_lo, in_hi, ph, exp_rdy, exp_oe, exp_we_n;
        in_lo    = (m_t >= 1) && (m_t <= W);
        in_hi    = (m_t > W) && (m_t <= 2*W);
        ph       = in_lo || in_hi;
        exp_rdy  = ((m_t == 0) && !(bus.mem_read || bus.mem_write)) || (m_t == 2*W + 1);
        exp_oe   = m_write && ph;
        exp_we_n = !(m_write && ph && (m_t != W) && (m_t != 2*W));
        check("ready", 32'(bus.ready), 32'(exp_rdy));
        check("dq_oe", 32'(bus.sram_dq_oe), 32'(exp_oe));
        check("we_n", 32'(bus.sram_we_n), 32'(exp_we_n));
        if (ph) check("sram_addr", 32'(bus.sram_addr), 32'({m_word[16:0], in_hi}));
        if (exp_oe) check("dq_out", 32'(bus.sram_dq_out), in_lo ? 32'(m_wdata[15:0]) : 32'(m_wdata[31:16]));
        if (exp_rdy) check("rdata", bus.rdata, m_rdata);
    end

    int          lat;
    logic [17:0] rec_addr [0:63];
    logic [15:0] rec_dq   [0:63];
    logic        rec_we   [0:63];
    logic        rec_oe   [0:63];
    logic        rec_rdy  [0:63];

    task automatic record(input int n);
        rec_addr[n] = bus.sram_addr;
        rec_dq[n]   = bus.sram_dq_out;
        rec_we[n]   = bus.sram_we_n;
        rec_oe[n]   = bus.sram_dq_oe;
        rec_rdy[n]  = bus.ready;
    endtask

    // Called just after a rising edge; returns just after the edge leaving DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input bit hold);
        int busy_rdy;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.address   = addr;
        bus.wdata     = data;
        lat = 0;
        @(negedge clk);
        record(0);
        while (lat < 40) begin
            @(posedge clk); #1;
            if (!hold) begin bus.mem_read = 1'b0; bus.mem_write = 1'b0; end
            @(negedge clk);
            lat++;
            record(lat);
            if (bus.ready) break;
        end
        check("latency", lat, 2*W + 1);
        busy_rdy = 0;
        for (int i = 0; i < lat; i++) busy_rdy += int'(rec_rdy[i]);
        check("ready_while_busy", busy_rdy, 0);
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.address   = '0;
        bus.wdata     = '0;
        #12;
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_we_n", 32'(bus.sram_we_n), 32'h1);
        check("rst_oe", 32'(bus.sram_dq_oe), 32'h0);
        check("rst_addr", 32'(bus.sram_addr), 32'h0);
        check("rst_dq_out", 32'(bus.sram_dq_out), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b1);
        check("st_addr_c1", 32'(rec_addr[1]), 32'h0);
        check("st_dq_c1", 32'(rec_dq[1]), 32'hBEEF);
        check("st_oe_c1", 32'(rec_oe[1]), 32'h1);
        check("st_we_c4", 32'(rec_we[4]), 32'h0);
        check("st_we_c5", 32'(rec_we[5]), 32'h1);
        check("st_addr_c6", 32'(rec_addr[6]), 32'h1);
        check("st_dq_c6", 32'(rec_dq[6]), 32'hDEAD);
        check("st_we_c9", 32'(rec_we[9]), 32'h0);
        check("st_we_c10", 32'(rec_we[10]), 32'h1);
        check("st_sram0", 32'(sram[0]), 32'hBEEF);
        check("st_sram1", 32'(sram[1]), 32'hDEAD);

        do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
        check("ld_addr_c1", 32'(rec_addr[1]), 32'h2);
        check("ld_addr_c6", 32'(rec_addr[6]), 32'h3);
        check("ld_oe_c3", 32'(rec_oe[3]), 32'h0);
        check("ld_we_c8", 32'(rec_we[8]), 32'h1);
        check("ld_rdata", bus.rdata, 32'h12345678);

        // Request held for cycle 0 only; the access must still run to DONE.
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        check("wd_rdata", bus.rdata, 32'hDEADBEEF);
        @(negedge clk);
        check("wd_idle_ready", 32'(bus.ready), 32'h1);
        @(posedge clk); #1;

        do_access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b1);
        do_access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b1);
        check("b2b_rdata", bus.rdata, 32'hCAFEF00D);
        check("b2b_addr_c1", 32'(rec_addr[1]), 32'h8);

        do_access(1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 1'b1);
        check("both_oe_c2", 32'(rec_oe[2]), 32'h1);
        check("both_we_c2", 32'(rec_we[2]), 32'h0);
        check("both_rdata", bus.rdata, 32'hCAFEF00D);
        check("both_sram0", 32'(sram[0]), 32'hF00D);

        // Store at 1060 interrupted by reset in its 7th cycle.
        bus.mem_write = 1'b1;
        bus.address   = 32'd1060;
        bus.wdata     = 32'h11223344;
        repeat (7) @(posedge clk);
        #3;
        check("pre_rst_we_n", 32'(bus.sram_we_n), 32'h0);
        check("pre_rst_addr", 32'(bus.sram_addr), 32'd19);
        rst_n         = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        check("rst_mid_we_n", 32'(bus.sram_we_n), 32'h1);
        check("rst_mid_oe", 32'(bus.sram_dq_oe), 32'h0);
        check("rst_mid_rdata", bus.rdata, 32'h0);
        check("rst_mid_ready", 32'(bus.ready), 32'h1);
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.ready), 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle_we_n", 32'(bus.sram_we_n), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
